// File: rtl/neuron_input_loader.sv
// Streaming front end for the floating-point neuron: converts signed fixed-point samples
// to IEEE-754 single precision and deserialises them into a double-buffered frame vector.
module neuron_input_loader #(
  parameter int N_INPUTS  = 49,
  parameter int IN_WIDTH  = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic                      vec_valid,
  input  logic                      vec_ready,
  output logic [32*N_INPUTS-1:0]    vec_data,
  output logic                      frame_err
);

  localparam int unsigned CW = $clog2(N_INPUTS + 1);
  localparam int unsigned IW = $clog2(N_INPUTS);

  logic                   run_q, run_d;
  logic [CW-1:0]          acc_cnt_q, acc_cnt_d;

  logic                   v1_q, v1_d;
  logic                   sign1_q, sign1_d;
  logic                   flush1_q, flush1_d;
  logic [IN_WIDTH-1:0]    mag1_q, mag1_d;

  logic                   v2_q, v2_d;
  logic                   flush2_q, flush2_d;
  logic [31:0]            f2_q, f2_d;

  logic [31:0]            fill_q [N_INPUTS];
  logic [31:0]            fill_d [N_INPUTS];
  logic [IW-1:0]          wr_idx_q, wr_idx_d;
  logic                   frame_done_q, frame_done_d;
  logic                   miss_q, miss_d;

  logic                   vec_valid_q, vec_valid_d;
  logic [32*N_INPUTS-1:0] vec_data_q, vec_data_d;
  logic                   frame_err_q, frame_err_d;

  logic                   accept;
  logic                   last_elem;
  logic                   early;
  logic                   xfer;

  int unsigned            msb;
  logic [23:0]            m24;
  logic [7:0]             exp_b;
  logic [22:0]            mant;

  assign s_ready   = run_q && (acc_cnt_q < CW'(N_INPUTS));
  assign accept    = s_valid && s_ready;
  assign last_elem = (acc_cnt_q == CW'(N_INPUTS - 1));
  assign early     = accept && s_last && !last_elem;
  assign xfer      = frame_done_q && (!vec_valid_q || vec_ready);

  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign frame_err = frame_err_q;

  // Stage 1: sign/magnitude; the most negative input maps to 2^(IN_WIDTH-1), which still fits.
  always_comb begin
    run_d    = 1'b1;
    v1_d     = accept;
    sign1_d  = s_data[IN_WIDTH-1];
    mag1_d   = s_data[IN_WIDTH-1] ? (~s_data + IN_WIDTH'(1)) : s_data;
    flush1_d = early;
  end

  // Stage 2: leading-one detect and normalise; exact because IN_WIDTH never exceeds 24.
  always_comb begin
    msb = 0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (mag1_q[i]) msb = i;
    end
    m24      = 24'(mag1_q);
    mant     = 23'(m24 << (23 - msb));
    exp_b    = 8'(127 + msb - FRAC_BITS);
    f2_d     = (mag1_q == '0) ? '0 : {sign1_q, exp_b, mant};
    v2_d     = v1_q;
    flush2_d = flush1_q;
  end

  always_comb begin
    fill_d       = fill_q;
    wr_idx_d     = wr_idx_q;
    frame_done_d = frame_done_q;
    if (v2_q) begin
      if (flush2_q) begin
        wr_idx_d = '0;
      end else begin
        fill_d[wr_idx_q] = f2_q;
        if (wr_idx_q == IW'(N_INPUTS - 1)) frame_done_d = 1'b1;
        else                               wr_idx_d     = wr_idx_q + IW'(1);
      end
    end
    if (xfer) begin
      frame_done_d = 1'b0;
      wr_idx_d     = '0;
    end
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (xfer)          acc_cnt_d = '0;
    else if (accept)   acc_cnt_d = early ? '0 : acc_cnt_q + CW'(1);

    miss_d = miss_q;
    if (accept && last_elem && !s_last) miss_d = 1'b1;
    if (xfer)                           miss_d = 1'b0;

    frame_err_d = early || (xfer && miss_q);
  end

  // A consume in the same cycle as a transfer keeps vec_valid high for back-to-back frames.
  always_comb begin
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;
    if (xfer) begin
      vec_valid_d = 1'b1;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        vec_data_d[32*i +: 32] = fill_q[i];
      end
    end else if (vec_ready) begin
      vec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      acc_cnt_q    <= '0;
      v1_q         <= 1'b0;
      sign1_q      <= 1'b0;
      flush1_q     <= 1'b0;
      mag1_q       <= '0;
      v2_q         <= 1'b0;
      flush2_q     <= 1'b0;
      f2_q         <= '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) fill_q[i] <= '0;
      wr_idx_q     <= '0;
      frame_done_q <= 1'b0;
      miss_q       <= 1'b0;
      vec_valid_q  <= 1'b0;
      vec_data_q   <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      run_q        <= run_d;
      acc_cnt_q    <= acc_cnt_d;
      v1_q         <= v1_d;
      sign1_q      <= sign1_d;
      flush1_q     <= flush1_d;
      mag1_q       <= mag1_d;
      v2_q         <= v2_d;
      flush2_q     <= flush2_d;
      f2_q         <= f2_d;
      fill_q       <= fill_d;
      wr_idx_q     <= wr_idx_d;
      frame_done_q <= frame_done_d;
      miss_q       <= miss_d;
      vec_valid_q  <= vec_valid_d;
      vec_data_q   <= vec_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_neuron_input_loader.sv
// Directed bench for neuron_input_loader: a FRAC_BITS=0 and a FRAC_BITS=8 instance share one stream.
module tb_neuron_input_loader;

  localparam int N = 49;
  typedef logic [32*N-1:0] frame_t;
  typedef int iq_t[$];

  typedef struct {
    string       name;
    bit          f8;
    int          frame;
    int          elem;
    logic [31:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_last, vec_ready;
  logic [15:0]  s_data;
  logic         s_ready0, vec_valid0, frame_err0;
  logic         s_ready8, vec_valid8, frame_err8;
  frame_t       vec_data0, vec_data8;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           accepts = 0;
  frame_t       cap0[$];
  frame_t       cap8[$];
  frame_t       expq[$];

  always #5 clk = ~clk;

  neuron_input_loader #(.N_INPUTS(N), .IN_WIDTH(16), .FRAC_BITS(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_last(s_last), .vec_valid(vec_valid0), .vec_ready(vec_ready), .vec_data(vec_data0),
    .frame_err(frame_err0));

  neuron_input_loader #(.N_INPUTS(N), .IN_WIDTH(16), .FRAC_BITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .s_last(s_last), .vec_valid(vec_valid8), .vec_ready(vec_ready), .vec_data(vec_data8),
    .frame_err(frame_err8));

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready0)    accepts++;
      if (vec_valid0 && vec_ready) cap0.push_back(vec_data0);
      if (vec_valid8 && vec_ready) cap8.push_back(vec_data8);
    end
  end

  initial begin
    #5ms;
    $display("Watchdog timeout: simulation stopped");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fmodel(int v, int f);
    real r;
    logic [63:0] b;
    int e;
    if (v == 0) return 32'h0;
    r = real'(v) / (2.0 ** f);
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic frame_t model_frame(iq_t v, int f);
    frame_t fr;
    fr = '0;
    for (int i = 0; i < N; i++) fr[32*i +: 32] = fmodel(v[i], f);
    return fr;
  endfunction

  function automatic iq_t seq(int base, int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(base + i);
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input frame_t act, input frame_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < N; i++) begin
        if (act[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s: element %0d got %h expected %h", name, i,
                   act[32*i +: 32], exp[32*i +: 32]);
          break;
        end
      end
    end
  endtask

  // last_every=0 never asserts s_last; otherwise s_last marks every last_every-th sample.
  task automatic stream(input iq_t vals, input int last_every);
    bit ok;
    for (int i = 0; i < vals.size(); i++) begin
      s_valid = 1'b1;
      s_data  = 16'(vals[i]);
      s_last  = (last_every > 0) && ((i % last_every) == last_every - 1);
      ok = 1'b0;
      for (int w = 0; w < 3000; w++) begin
        @(negedge clk);
        if (s_ready0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        n_tests++; n_fail++;
        $display("FAIL stream_timeout: sample %0d not accepted, s_ready=%b required 1", i, s_ready0);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_vv(input string name);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (vec_valid0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s: vec_valid=0 after 500 cycles, required 1", name);
    end
  endtask

  vec_t   tbl[$];
  iq_t    vals, abc;
  frame_t snap, t;
  int     nc;
  bit     ok;

  initial begin
    tbl.push_back('{"basic_e0",  1'b0, 0, 0,  32'h3F800000});
    tbl.push_back('{"basic_e1",  1'b0, 0, 1,  32'h40000000});
    tbl.push_back('{"basic_e48", 1'b0, 0, 48, 32'h42440000});
    tbl.push_back('{"edge_zero", 1'b0, 1, 0,  32'h00000000});
    tbl.push_back('{"edge_m1",   1'b0, 1, 1,  32'hBF800000});
    tbl.push_back('{"edge_max",  1'b0, 1, 2,  32'h46FFFE00});
    tbl.push_back('{"edge_min",  1'b0, 1, 3,  32'hC7000000});
    tbl.push_back('{"edge_one",  1'b0, 1, 6,  32'h3F800000});
    tbl.push_back('{"f8_256",    1'b1, 1, 4,  32'h3F800000});
    tbl.push_back('{"f8_m128",   1'b1, 1, 5,  32'hBF000000});
    tbl.push_back('{"f8_m1",     1'b1, 1, 1,  32'hBB800000});

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec_valid", 32'(vec_valid0), 32'd0);
    check("rst_s_ready", 32'(s_ready0), 32'd0);
    check("rst_frame_err", 32'(frame_err0), 32'd0);
    check_frame("rst_vec_data", vec_data0, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s_ready_after_release", 32'(s_ready0), 32'd1);

    // Basic frame and exact latency: vec_valid on the 3rd edge after the final accept.
    vec_ready = 1'b1;
    expq.push_back(model_frame(seq(1, N), 0));
    stream(seq(1, N), N);
    repeat (2) @(posedge clk);
    #1;
    check("latency_edge2_low", 32'(vec_valid0), 32'd0);
    @(posedge clk); #1;
    check("latency_edge3_high", 32'(vec_valid0), 32'd1);
    @(posedge clk); #1;
    check("consumed_low", 32'(vec_valid0), 32'd0);

    vals = '{0, -1, 32767, -32768, 256, -128};
    while (vals.size() < N) vals.push_back(1);
    expq.push_back(model_frame(vals, 0));
    stream(vals, N);
    wait_vv("edge_frame");
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (cap0.size() >= 2 && cap8.size() >= 2) begin
      n_tests--;
      foreach (tbl[k]) begin
        t = tbl[k].f8 ? cap8[tbl[k].frame] : cap0[tbl[k].frame];
        check(tbl[k].name, t[32*tbl[k].elem +: 32], tbl[k].exp);
      end
    end else begin
      n_fail++;
      $display("FAIL capture_count: got %0d/%0d frames required 2", cap0.size(), cap8.size());
    end

    // Missing s_last on the final element: frame still emitted, error flagged with the transfer.
    expq.push_back(model_frame(seq(200, N), 0));
    stream(seq(200, N), 0);
    wait_vv("missing_last");
    check("missing_last_err", 32'(frame_err0), 32'd1);
    @(negedge clk);
    check("missing_last_err_pulse", 32'(frame_err0), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: A held, B completes in the fill buffer, C waits for the transfer.
    vec_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 3*N; i++) abc.push_back((i / N + 1) * 1000 + (i % N) + 1);
    expq.push_back(model_frame(seq(1001, N), 0));
    expq.push_back(model_frame(seq(2001, N), 0));
    expq.push_back(model_frame(seq(3001, N), 0));
    fork
      stream(abc, N);
      begin
        wait_vv("bp_frame_a");
        snap = vec_data0;
        check_frame("bp_frame_a", snap, model_frame(seq(1001, N), 0));
        ok = 1'b0;
        for (int w = 0; w < 500; w++) begin
          @(negedge clk); #1;
          if (accepts >= 2*N) begin ok = 1'b1; break; end
        end
        if (!ok) begin
          n_tests++; n_fail++;
          $display("FAIL bp_fill_b: accepts=%0d required %0d", accepts, 2*N);
        end
        repeat (6) @(negedge clk);
        check("bp_accepts_saturated", 32'(accepts), 32'(2*N));
        check("bp_s_ready_low", 32'(s_ready0), 32'd0);
        check("bp_vec_valid_held", 32'(vec_valid0), 32'd1);
        check_frame("bp_a_stable", vec_data0, snap);
        @(posedge clk); #1;
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        check("bp_b_vec_valid", 32'(vec_valid0), 32'd1);
        check("bp_s_ready_rise", 32'(s_ready0), 32'd1);
        check_frame("bp_frame_b", vec_data0, model_frame(seq(2001, N), 0));
        repeat (5) @(posedge clk);
        #1;
        vec_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;

    // Back-to-back with s_valid continuously high.
    accepts = 0;
    vals = seq(301, 3*N);
    for (int f = 0; f < 3; f++) expq.push_back(model_frame(seq(301 + f*N, N), 0));
    stream(vals, N);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_accepts", 32'(accepts), 32'(3*N));

    // Early s_last on element 10 discards the partial frame.
    nc = cap0.size();
    stream(seq(100, 11), 11);
    check("early_err", 32'(frame_err0), 32'd1);
    @(posedge clk); #1;
    check("early_err_pulse", 32'(frame_err0), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("early_no_vec", 32'(cap0.size() - nc), 32'd0);
    expq.push_back(model_frame(seq(1, N), 0));
    stream(seq(1, N), N);
    repeat (6) @(posedge clk);
    #1;

    // Reset with a held vector and a partial frame in progress.
    vec_ready = 1'b0;
    stream(seq(600, N), N);
    wait_vv("reset_held");
    stream(seq(700, 20), 0);
    rst_n = 1'b0;
    #1;
    check("reset_vec_valid", 32'(vec_valid0), 32'd0);
    check("reset_s_ready", 32'(s_ready0), 32'd0);
    check_frame("reset_vec_data", vec_data0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vec_ready = 1'b1;
    expq.push_back(model_frame(seq(800, N), 0));
    stream(seq(800, N), N);
    repeat (8) @(posedge clk);
    #1;

    check("frame_count", 32'(cap0.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < cap0.size(); i++) begin
      check_frame($sformatf("frame_%0d", i), cap0[i], expq[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_input_loader.md
Name: neuron_input_loader

Overview:
Streaming front end for the 49-input floating-point neuron.
- Accepts signed fixed-point samples one per cycle over a valid/ready stream.
- Converts each sample to IEEE-754 single precision, the inverse of the neuron's float-to-int16 stage.
- Deserialises the samples into a full N_INPUTS-wide float vector, double-buffered.
- Presents the vector to the neuron's parallel input with a valid/ready handshake.

Parameters:
N_INPUTS, 49, elements per frame (vector width in 32-bit words); legal range 2..64.
IN_WIDTH, 16, width of signed two's-complement input sample; legal range 2..24.
FRAC_BITS, 0, fractional bits of the input sample; value = sample / 2^FRAC_BITS; legal range 0..IN_WIDTH-1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input sample valid
s_ready  output  1  loader can accept a sample
s_data  input  IN_WIDTH  signed fixed-point sample
s_last  input  1  marks final sample of a frame
vec_valid  output  1  vec_data holds a complete frame
vec_ready  input  1  consumer takes the frame
vec_data  output  32*N_INPUTS  element i at bits [32*i+31:32*i], IEEE-754 single
frame_err  output  1  one-cycle pulse on s_last misalignment

Behaviour:
- Reset (async assert, sync release):
  - vec_valid=0, vec_data=0, frame_err=0, s_ready=0 while rst_n low.
  - All counters, pipeline valids and flags are cleared.
  - Reset mid-frame discards the partial frame and any held vector.
- Sample acceptance:
  - A transfer occurs when s_valid&&s_ready at a rising edge.
  - acc_cnt (0..N_INPUTS) counts accepted samples of the current frame.
  - s_ready = rst-released && acc_cnt<N_INPUTS.
- Conversion pipeline (2 register stages, in order, no stall):
  - Stage 1 registers sign and magnitude (|x|, IN_WIDTH bits; -2^(IN_WIDTH-1) handled exactly).
  - Stage 2 performs leading-one detect and normalise:
    - exponent = 127 + msb_pos - FRAC_BITS
    - mantissa = bits below the leading one, left-aligned into 23 bits.
  - Conversion is exact; no rounding is needed since IN_WIDTH<=24.
  - Zero converts to 0x00000000; -0 is never produced.
- Fill buffer:
  - A converted element is written to fill[wr_idx] two cycles after acceptance, then wr_idx increments.
  - The write of index N_INPUTS-1 sets frame_done.
- Transfer to output:
  - Occurs on the edge where frame_done && (!vec_valid || vec_ready).
  - Copies fill into vec_data, sets vec_valid=1, clears frame_done, sets acc_cnt=0 and wr_idx=0.
  - s_ready therefore rises the cycle after the transfer.
  - Minimum latency: vec_valid rises on the 3rd edge after the edge that accepted the final sample.
- Output handshake:
  - vec_valid&&vec_ready with no pending frame_done: vec_valid drops to 0 next cycle; vec_data holds its last value.
  - Simultaneous consume and transfer: the new frame is loaded and vec_valid stays 1, giving back-to-back frames.
  - vec_data is stable while vec_valid=1 and vec_ready=0.
- Backpressure:
  - With the output full, one further frame can complete in the fill buffer.
  - acc_cnt then saturates at N_INPUTS and s_ready stays 0 until the transfer.
- s_last rules:
  - s_last on the sample that is element N_INPUTS-1: normal.
  - s_last missing on element N_INPUTS-1: frame is emitted normally and frame_err pulses with the transfer.
  - s_last early (element k<N_INPUTS-1):
    - frame_err pulses on the cycle after acceptance; acc_cnt resets to 0 at acceptance.
    - The early sample's pipeline entry is tagged flush. When it exits, it is not written and wr_idx resets to 0.
    - Earlier in-flight elements are written normally and overwritten later.
    - The next accepted sample is element 0 of a new frame.
- frame_err from simultaneous events is ORed into a single pulse.

Test Plan:
- FRAC_BITS=0: stream samples 1..49, s_last on the 49th, vec_ready=1 → vec_valid 3 edges after the last accept; element0=0x3F800000, element1=0x40000000, element48=0x42440000; vec_valid low next cycle.
- Edge values in one frame (0, -1, 32767, -32768, rest 1) → elements 0x00000000, 0xBF800000, 0x46FFFE00, 0xC7000000; FRAC_BITS=8 build: sample 256 → 0x3F800000, sample -128 → 0xBF000000.
- Backpressure:
  - vec_ready=0, three frames offered continuously → frame A held in vec_data unchanged; frame B accepted; s_ready low after B's 49th accept.
  - Raise vec_ready for 1 cycle → B loads with vec_valid staying 1; s_ready rises next cycle; C then streams.
- Back-to-back with vec_ready=1 and s_valid always high → exactly 49 accepts per frame, no lost or duplicated elements, frame order preserved.
- Early s_last on element 10 (values 100..110), then 49 samples 1..49 → frame_err one-cycle pulse, no vec_valid for the partial frame; next vector equals 1..49.
- rst_n low mid-frame (after 20 accepts) and while a vector is held → vec_valid=0, vec_data=0 immediately; after release, a fresh 49-sample frame emits correctly with no residue.
